// File: rtl/signed_div.sv
// signed_div -- sequential signed fixed-point divider, Q3.6 / Q3.6 -> Q.6.
//
// Computes y = trunc_toward_zero((a * 64) / b) on operand magnitudes with a
// restoring radix-2 divider that retires one quotient bit per clock.
// A request takes exactly 17 clocks from the edge that samples start to
// the done pulse, independent of operand values (including b == 0).
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  request, sampled only while idle
//   a, b   9-bit signed Q3.6 dividend / divisor
//   busy   high while a division is in progress
//   done   one-cycle pulse when y / dz are updated
//   y      18-bit signed quotient, 6 fractional bits, held until next done
//   dz     divide-by-zero flag qualifying y
module signed_div (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [8:0]  a,
  input  logic [8:0]  b,
  output logic        busy,
  output logic        done,
  output logic [17:0] y,
  output logic        dz
);

  typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

  state_t      state, state_nxt;
  logic [3:0]  ctr;
  logic [9:0]  rem;    // partial remainder; always < |b| <= 256 between steps
  logic [14:0] dq;     // dividend bits shift out the top, quotient bits in the bottom
  logic [8:0]  bmag;
  logic        neg, bzero, azero;

  // 9-bit unsigned magnitudes: -256 (9'h100) negates to itself, read as 256.
  logic [8:0]  amag, bmag_in;
  assign amag    = a[8] ? 9'(-a) : a;
  assign bmag_in = b[8] ? 9'(-b) : b;

  // One restoring step: bring down the next dividend bit, trial-subtract.
  logic [9:0]  rem_sh;
  logic [10:0] diff;
  logic        ge;
  assign rem_sh = {rem[8:0], dq[14]};
  assign diff   = {1'b0, rem_sh} - {2'b00, bmag};
  assign ge     = ~diff[10];

  // Final signed result. The quotient magnitude is at most 16384, so it
  // fits 15 bits and negation into 18 bits never overflows; -0 is 0.
  logic [17:0] qmag, y_res;
  assign qmag = {3'b000, dq};

  always_comb begin
    y_res = neg ? 18'(-qmag) : qmag;
    if (bzero) begin
      // Saturate by dividend sign; with b == 0 the sign flag equals a's sign.
      if (azero)    y_res = 18'h00000;
      else if (neg) y_res = 18'h20000;
      else          y_res = 18'h1FFFF;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = CALC;
      CALC: if (ctr == 4'd0) state_nxt = SIGN;
      SIGN: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ctr   <= '0;
      rem   <= '0;
      dq    <= '0;
      bmag  <= '0;
      neg   <= 1'b0;
      bzero <= 1'b0;
      azero <= 1'b0;
      done  <= 1'b0;
      y     <= '0;
      dz    <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        IDLE: if (start) begin
          dq    <= {amag, 6'b0};
          bmag  <= bmag_in;
          neg   <= a[8] ^ b[8];
          bzero <= (b == 9'd0);
          azero <= (a == 9'd0);
          rem   <= '0;
          ctr   <= 4'd14;
        end
        CALC: begin
          rem <= ge ? diff[9:0] : rem_sh;
          dq  <= {dq[13:0], ge};
          if (ctr != 4'd0) ctr <= ctr - 4'd1;
        end
        SIGN: begin
          y    <= y_res;
          dz   <= bzero;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_div.sv
module tb_signed_div;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [8:0]  a = '0, b = '0;
  logic        busy, done, dz;
  logic [17:0] y;

  signed_div dut (.clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
                  .busy(busy), .done(done), .y(y), .dz(dz));

  always #5 clk = ~clk;

  int vectors = 0;
  int errs    = 0;
  int cyc     = 0;

  typedef struct { logic [17:0] y; logic dz; int cyc; } exp_t;
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: quotient from plain integer arithmetic (C-style division
  // truncates toward zero), saturation table for b == 0.
  function automatic exp_t ref_model(input logic [8:0] av, input logic [8:0] bv);
    exp_t e;
    int ai, bi, q;
    logic [31:0] t;
    ai = $signed(av);
    bi = $signed(bv);
    e.cyc = 0;
    if (bi == 0) begin
      e.dz = 1'b1;
      if (ai > 0)      e.y = 18'h1FFFF;
      else if (ai < 0) e.y = 18'h20000;
      else             e.y = 18'h00000;
    end else begin
      q = (ai * 64) / bi;
      t = q;
      e.y  = t[17:0];
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request,
  // both in value and in the cycle it appears.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        vectors++; errs++;
        $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("y", 32'(y), 32'(e.y));
        chk("dz", 32'(dz), 32'(e.dz));
        chk("latency", cyc, e.cyc);
      end
    end
  end

  // Called at a negedge; waits (bounded) until the divider is idle.
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin @(negedge clk); n++; end
    if (busy) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic push(input logic [17:0] ey, input logic edz, input int ecyc);
    exp_t e;
    e.y = ey; e.dz = edz; e.cyc = ecyc;
    sb.push_back(e);
  endtask

  // One-cycle start pulse; done is expected after the 17th edge.
  task automatic issue(input logic [8:0] av, input logic [8:0] bv,
                       input logic [17:0] ey, input logic edz);
    wait_idle();
    a = av; b = bv; start = 1'b1;
    push(ey, edz, cyc + 17);
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom;   // must not disturb the operation in flight
  endtask

  task automatic issue_ref(input logic [8:0] av, input logic [8:0] bv);
    exp_t e;
    e = ref_model(av, bv);
    issue(av, bv, e.y, e.dz);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
    if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int c;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_y", 32'(y), 0);
    chk("rst_dz", 32'(dz), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed values
    issue(9'h040, 9'h080, 18'h00020, 1'b0);
    issue(9'h1C0, 9'h040, 18'h3FFC0, 1'b0);
    issue(9'h040, 9'h0C0, 18'h00015, 1'b0);
    issue(9'h1C0, 9'h0C0, 18'h3FFEB, 1'b0);
    issue(9'h100, 9'h1FF, 18'h04000, 1'b0);
    issue(9'h040, 9'h000, 18'h1FFFF, 1'b1);
    issue(9'h1C0, 9'h000, 18'h20000, 1'b1);
    issue(9'h000, 9'h000, 18'h00000, 1'b1);
    issue(9'h000, 9'h1C0, 18'h00000, 1'b0);
    drain();

    // Start while busy is ignored: only the first result appears.
    issue(9'h0C0, 9'h040, 18'h000C0, 1'b0);
    repeat (4) @(negedge clk);
    chk("busy_mid", 32'(busy), 1);
    a = 9'h040; b = 9'h000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    chk("y_held", 32'(y), 32'h000C0);

    // Start held through the done cycle: back-to-back acceptance.
    wait_idle();
    c = cyc;
    a = 9'h080; b = 9'h040; start = 1'b1;
    push(18'h00080, 1'b0, c + 17);
    @(negedge clk);
    a = 9'h1C0; b = 9'h080;
    push(18'h3FFE0, 1'b0, c + 34);
    repeat (17) @(negedge clk);
    start = 1'b0;
    drain();

    // Reset mid-calculation aborts without a done pulse.
    issue(9'h0FF, 9'h003, 18'h00000, 1'b0);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_y", 32'(y), 0);
    chk("arst_dz", 32'(dz), 0);
    chk("arst_done", 32'(done), 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);  // any stray done here is flagged by the monitor
    issue_ref(9'h0FF, 9'h003);
    drain();

    // Random sweep, back-to-back, with extra weight on edge operands.
    for (int i = 0; i < 1200; i++) begin
      logic [8:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 9))
        0: rb = 9'h000;
        1: ra = 9'h100;
        2: rb = ($urandom_range(0, 1) != 0) ? 9'h001 : 9'h1FF;
        3: ra = 9'h000;
        default: ;
      endcase
      issue_ref(ra, rb);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
